// File: rtl/comb_sweep_sequencer_if.sv
// Result-record stream between the sweep sequencer and the results checker.
// The master side (sequencer) presents one record per swept vector and holds
// it until the slave side accepts it with res_ready.
interface comb_sweep_sequencer_if #(
  parameter int IN_W  = 4,
  parameter int OUT_W = 3
);
  logic             res_valid;
  logic             res_ready;
  logic [IN_W-1:0]  res_vec;
  logic [OUT_W-1:0] res_out;
  logic             res_unstable;

  modport master (
    output res_valid,
    output res_vec,
    output res_out,
    output res_unstable,
    input  res_ready
  );

  modport slave (
    input  res_valid,
    input  res_vec,
    input  res_out,
    input  res_unstable,
    output res_ready
  );
endinterface

// File: rtl/comb_sweep_sequencer.sv
// Exhaustive input sweep sequencer for a small combinational netlist.
// Each vector is driven, held for SETTLE_CYC cycles, then sampled on
// STABLE_CYC consecutive cycles. Any change between samples marks the vector
// unstable (oscillating). One record per vector leaves on the result stream.
module comb_sweep_sequencer #(
  parameter int IN_W       = 4,
  parameter int OUT_W      = 3,
  parameter int SETTLE_CYC = 4,
  parameter int STABLE_CYC = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  abort_i,
  output logic [IN_W-1:0]       dut_in_o,
  output logic                  dut_oe_o,
  input  logic [OUT_W-1:0]      dut_out_i,
  comb_sweep_sequencer_if.master res_if,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [IN_W:0]         unstable_cnt_o
);

  // One shared down-counter serves both the settle and the sample phases.
  localparam int MAX_CYC = (SETTLE_CYC > STABLE_CYC) ? SETTLE_CYC : STABLE_CYC;
  localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [TW-1:0]   SETTLE_LOAD = TW'(SETTLE_CYC - 1);
  localparam logic [TW-1:0]   STABLE_LOAD = TW'(STABLE_CYC - 1);
  localparam logic [TW-1:0]   TIMER_ZERO  = {TW{1'b0}};
  localparam logic [TW-1:0]   TIMER_ONE   = TW'(1);
  localparam logic [IN_W-1:0] LAST_VEC    = {IN_W{1'b1}};
  localparam logic [IN_W-1:0] VEC_ONE     = IN_W'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETTLE = 3'd1,
    S_SAMPLE = 3'd2,
    S_EMIT   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [IN_W-1:0]   vec_q, vec_d;
  logic [OUT_W-1:0]  ref_q, ref_d;
  logic              unst_q, unst_d;
  logic [IN_W:0]     cnt_q, cnt_d;
  logic              valid_q, valid_d;
  logic              oe_q, oe_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              xfer_s;

  assign xfer_s = valid_q & res_if.res_ready;

  // Next-state and output decode; abort overrides everything outside IDLE.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    vec_d   = vec_q;
    ref_d   = ref_q;
    unst_d  = unst_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    oe_d    = oe_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    if (abort_i && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      valid_d = 1'b0;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i && !abort_i) begin
            vec_d   = {IN_W{1'b0}};
            timer_d = SETTLE_LOAD;
            oe_d    = 1'b1;
            busy_d  = 1'b1;
            cnt_d   = {(IN_W+1){1'b0}};
            state_d = S_SETTLE;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_SETTLE: begin
          if (timer_q == TIMER_ZERO) begin
            timer_d = STABLE_LOAD;
            state_d = S_SAMPLE;
          end else begin
            timer_d = timer_q - TIMER_ONE;
          end
        end
        S_SAMPLE: begin
          // The first sample becomes the reference; later ones are compared.
          if (timer_q == STABLE_LOAD) begin
            ref_d  = dut_out_i;
            unst_d = 1'b0;
          end else if (dut_out_i != ref_q) begin
            unst_d = 1'b1;
          end else begin
            unst_d = unst_q;
          end
          if (timer_q == TIMER_ZERO) begin
            valid_d = 1'b1;
            state_d = S_EMIT;
          end else begin
            timer_d = timer_q - TIMER_ONE;
          end
        end
        S_EMIT: begin
          // Record stays frozen until accepted; no sampling while stalled.
          if (xfer_s) begin
            valid_d = 1'b0;
            cnt_d   = cnt_q + {{IN_W{1'b0}}, unst_q};
            if (vec_q == LAST_VEC) begin
              done_d  = 1'b1;
              oe_d    = 1'b0;
              busy_d  = 1'b0;
              state_d = S_DONE;
            end else begin
              vec_d   = vec_q + VEC_ONE;
              timer_d = SETTLE_LOAD;
              state_d = S_SETTLE;
            end
          end else begin
            state_d = S_EMIT;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
          valid_d = 1'b0;
          oe_d    = 1'b0;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      timer_q <= {TW{1'b0}};
      vec_q   <= {IN_W{1'b0}};
      ref_q   <= {OUT_W{1'b0}};
      unst_q  <= 1'b0;
      cnt_q   <= {(IN_W+1){1'b0}};
      valid_q <= 1'b0;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      vec_q   <= vec_d;
      ref_q   <= ref_d;
      unst_q  <= unst_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      oe_q    <= oe_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign dut_in_o            = vec_q;
  assign dut_oe_o            = oe_q;
  assign busy_o              = busy_q;
  assign done_o              = done_q;
  assign unstable_cnt_o      = cnt_q;
  assign res_if.res_valid    = valid_q;
  assign res_if.res_vec      = vec_q;
  assign res_if.res_out      = ref_q;
  assign res_if.res_unstable = unst_q;

endmodule
